mem_port_arbiter: RTL

//   Shares one single-port memory between instruction fetch (I, read-only) and

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: FSM state, access-size codes, port ids
// and the alignment rule used to reject accesses before they reach memory.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] BHW_BYTE = 2'd0;
  localparam logic [1:0] BHW_HALF = 2'd1;
  localparam logic [1:0] BHW_WORD = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Size code 3 has no meaning and is rejected like a misaligned access.
  function automatic logic bad_access(input logic [1:0] bhw, input logic [1:0] addr_lo);
    case (bhw)
      BHW_BYTE: return 1'b0;
      BHW_HALF: return addr_lo[0];
      BHW_WORD: return (addr_lo != 2'b00);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and load/store. With MEM_ARB_RR_EN defined the
// port not granted last wins a tie; otherwise the data port always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_grant,
  output logic o_win
);

`ifdef MEM_ARB_RR_EN
  logic r_last;

  // Reset to "D granted last" so the first tie goes to fetch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= PORT_D;
    end else if (i_grant) begin
      r_last <= o_win;
    end
  end

  always_comb begin
    o_win = PORT_I;
    if (i_req_i && i_req_d) begin
      o_win = (r_last == PORT_I) ? PORT_D : PORT_I;
    end else if (i_req_d) begin
      o_win = PORT_D;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{i_clk, i_rst, i_grant, i_req_i};

  // Data port first: it belongs to the older instruction in the pipeline.
  assign o_win = i_req_d ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D) with a
// latched command and fixed memory latency. Tie policy set by MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [1:0]    d_bhw,
  input  logic          d_sext,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [1:0]    m_bhw,
  output logic          m_sext,
  input  logic [DW-1:0] m_rdata,
  output state_t        dbg_state
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_win, r_cmd_we;
  logic          r_m_en, r_m_we, r_m_sext;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic [1:0]    r_m_bhw;
  logic          r_i_ack, r_i_err, r_d_ack, r_d_err;
  logic [DW-1:0] r_i_rdata, r_d_rdata;

  logic          w_grant, w_win, w_we, w_sext, w_bad;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [1:0]    w_bhw;

  assign w_grant = (r_state == IDLE) && (i_req || d_req);

  mem_arb_pick u_pick (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_req_i (i_req),
    .i_req_d (d_req),
    .i_grant (w_grant),
    .o_win   (w_win)
  );

  // Fetch is presented as a plain aligned word read.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = i_addr;
    w_wdata = '0;
    w_bhw   = BHW_WORD;
    w_sext  = 1'b0;
    if (w_win == PORT_D) begin
      w_we    = d_we;
      w_addr  = d_addr;
      w_wdata = d_wdata;
      w_bhw   = d_bhw;
      w_sext  = d_sext;
    end
    w_bad = bad_access(w_bhw, w_addr[1:0]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_win     <= PORT_I;
      r_cmd_we  <= 1'b0;
      r_m_en    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_m_bhw   <= '0;
      r_m_sext  <= 1'b0;
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= '0;
    end else begin
      r_m_en  <= 1'b0;
      r_m_we  <= 1'b0;
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        IDLE: if (w_grant) begin
          r_win     <= w_win;
          r_cmd_we  <= w_we;
          r_m_addr  <= w_addr;
          r_m_wdata <= w_wdata;
          r_m_bhw   <= w_bhw;
          r_m_sext  <= w_sext;
          if (w_bad) begin
            r_state <= DONE;
            if (w_win == PORT_D) begin
              r_d_ack <= 1'b1;
              r_d_err <= 1'b1;
            end else begin
              r_i_ack <= 1'b1;
              r_i_err <= 1'b1;
            end
          end else begin
            r_state <= ISSUE;
            r_m_en  <= 1'b1;
            r_m_we  <= w_we;
          end
        end
        ISSUE: begin
          r_cnt   <= LAT;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // Last wait cycle: memory data is valid now; stores leave rdata alone.
          if (r_cnt == 4'd1) begin
            r_state <= DONE;
            if (r_win == PORT_D) begin
              r_d_ack <= 1'b1;
              r_d_err <= 1'b0;
              if (!r_cmd_we) r_d_rdata <= m_rdata;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_err   <= 1'b0;
              r_i_rdata <= m_rdata;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_ack     = r_i_ack;
  assign i_rdata   = r_i_rdata;
  assign i_err     = r_i_err;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign m_en      = r_m_en;
  assign m_we      = r_m_we;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign m_bhw     = r_m_bhw;
  assign m_sext    = r_m_sext;
  assign dbg_state = r_state;

endmodule
